// File: rtl/full_adder_unit_pkg.sv
// Shared arithmetic constants and helpers for the full-adder unit.
package full_adder_unit_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Result width: sum bits plus the carry-out of the MSB cell.
  function automatic int fa_res_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit; master drives operands, slave returns results.
interface full_adder_unit_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_valid;

  modport master (output in_valid, a, b, c, input s, cout, out_valid);
  modport slave  (input in_valid, a, b, c, output s, cout, out_valid);
endinterface

// File: rtl/full_adder_unit_fa_cell.sv
// Combinational 1-bit full adder, the leaf of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder: {cout, s} = a + b + c, one cycle latency.
module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic             clk,
  input logic             rst,
  full_adder_unit_if.slave bus
);
  localparam int RW = fa_res_width(WIDTH);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [RW-1:0]    res_d;
  logic [RW-1:0]    res_q;
  logic             vld_q;

  assign carry[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a   (bus.a[i]),
      .b   (bus.b[i]),
      .cin (carry[i]),
      .s   (sum_d[i]),
      .cout(carry[i+1])
    );
  end

  assign res_d = {carry[WIDTH], sum_d};

  // Result holds when no new operands arrive; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) res_q <= res_d;
    end
  end

  assign bus.s         = res_q[WIDTH-1:0];
  assign bus.cout      = res_q[WIDTH];
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_full_adder_unit.sv
// Directed + randomized bench for full_adder_unit at WIDTH 1, 8 and 16.
module tb_full_adder_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_adder_unit_if #(.WIDTH(1))  if1 ();
  full_adder_unit_if #(.WIDTH(8))  if8 ();
  full_adder_unit_if #(.WIDTH(16)) if16 ();

  full_adder_unit #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  full_adder_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  full_adder_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r1;
    logic [8:0]  r8;
    logic [16:0] r16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        c1;

    if1.in_valid = 0;  if1.a = '0;  if1.b = '0;  if1.c = 0;
    if8.in_valid = 0;  if8.a = '0;  if8.b = '0;  if8.c = 0;
    if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.c = 0;

    // Reset state
    tick(); tick();
    chk("reset_w1",  {if1.out_valid, if1.cout, if1.s}, 0);
    chk("reset_w8",  {if8.out_valid, if8.cout, if8.s}, 0);
    chk("reset_w16", {if16.out_valid, if16.cout, if16.s}, 0);
    rst = 0;

    // WIDTH=1 exhaustive truth table
    for (int v = 0; v < 8; v++) begin
      if1.in_valid = 1;
      if1.a = v[2]; if1.b = v[1]; if1.c = v[0];
      r1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      tick();
      chk($sformatf("truth_%0d%0d%0d", v[2], v[1], v[0]), {if1.cout, if1.s}, r1);
      chk("truth_valid", if1.out_valid, 1);
    end

    // WIDTH=1 toggle: a every cycle, b and c together every 2 cycles
    for (int k = 0; k < 8; k++) begin
      if1.a = k[0]; if1.b = k[1]; if1.c = k[1];
      r1 = 2'(k[0]) + 2'(k[1]) + 2'(k[1]);
      tick();
      chk($sformatf("toggle_%0d", k), {if1.out_valid, if1.cout, if1.s}, {1'b1, r1});
    end
    if1.in_valid = 0;

    // WIDTH=8 overflow and all-ones
    if8.in_valid = 1; if8.a = 8'hFF; if8.b = 8'h01; if8.c = 0;
    tick();
    chk("ovf_ff_01", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b1, 8'h00});
    if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1;
    tick();
    chk("all_ones", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b1, 8'hFF});

    // Hold while in_valid is low
    if8.a = 8'd5; if8.b = 8'd3; if8.c = 0;
    tick();
    chk("add_5_3", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b0, 8'h08});
    if8.in_valid = 0; if8.a = 8'h7F;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_%0d", k), {if8.out_valid, if8.cout, if8.s}, {1'b0, 1'b0, 8'h08});
    end

    // Inputs wiggling between edges must not matter
    if8.in_valid = 1; if8.a = 8'h10; if8.b = 8'h20; if8.c = 0;
    #2 if8.a = 8'hEE; if8.c = 1;
    #2 if8.a = 8'h10; if8.c = 0;
    tick();
    chk("glitch", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b0, 8'h30});

    // Asynchronous reset mid-stream
    if8.a = 8'd5; if8.b = 8'd3; if8.c = 0;
    tick();
    chk("pre_rst", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b0, 8'h08});
    #2 rst = 1;
    #1;
    chk("async_rst", {if8.out_valid, if8.cout, if8.s}, 0);
    if8.in_valid = 0;
    @(negedge clk);
    rst = 0;
    tick();
    chk("post_rst_idle", {if8.out_valid, if8.cout, if8.s}, 0);
    if8.in_valid = 1; if8.a = 8'h12; if8.b = 8'h34; if8.c = 1;
    tick();
    chk("post_rst_first", {if8.out_valid, if8.cout, if8.s}, {1'b1, 1'b0, 8'h47});
    if8.in_valid = 0;

    // WIDTH=16 random back-to-back, reference is plain 17-bit addition
    if16.in_valid = 1;
    for (int k = 0; k < 1000; k++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c1 = 1'($urandom);
      if (k % 50 == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; c1 = 1; end
      if16.a = a16; if16.b = b16; if16.c = c1;
      r16 = 17'(a16) + 17'(b16) + 17'(c1);
      tick();
      chk($sformatf("rand_%0d", k), {if16.out_valid, if16.cout, if16.s}, {1'b1, r16});
    end
    if16.in_valid = 0;
    tick();
    chk("rand_valid_drop", if16.out_valid, 0);

    // A few random WIDTH=8 sums for good measure
    if8.in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c1 = 1'($urandom);
      if8.a = a8; if8.b = b8; if8.c = c1;
      r8 = 9'(a8) + 9'(b8) + 9'(c1);
      tick();
      chk($sformatf("rand8_%0d", k), {if8.out_valid, if8.cout, if8.s}, {1'b1, r8});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Registered full-adder block: adds operands a and b plus carry-in c and produces sum s and carry-out cout.
- Built as a ripple chain of 1-bit full-adder cells, WIDTH bits wide, with a single output register stage.
- Used as the arithmetic leaf in datapaths and as the reference 1-bit adder (WIDTH=1) in lab-level designs.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a/b/c for capture this cycle.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- c  input  1  carry-in.
- s  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  high for one cycle when s/cout carry a new result.

Behaviour:
- Reset: rst high forces s=0, cout=0, out_valid=0 immediately, independent of clk. Outputs stay 0 while rst is high. The first capture is on the first rising clk edge after rst deasserts.
- Cell function, bit i: s_i = a_i XOR b_i XOR c_i; c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)). c_0 = c.
- Arithmetic: {cout, s} = a + b + c, computed exactly in WIDTH+1 bits. There is no wrap loss; overflow appears only in cout.
- Latency is one cycle:
  - On a rising edge with in_valid=1, {cout, s} register the combinational result and out_valid goes to 1.
  - On a rising edge with in_valid=0, s and cout hold their previous values and out_valid goes to 0.
- Throughput is one operation per cycle. Back-to-back valid inputs give back-to-back results with no bubbles.
- Inputs are sampled only at clk edges. Input glitches between edges have no effect.
- If rst asserts mid-operation, any in-flight result is discarded. After rst falls, no stale out_valid appears.
- All-ones case: a=b=all ones and c=1 gives s=all ones, cout=1.
- X-free: for defined inputs, outputs are never X after reset.
- No internal state exists beyond the output registers and out_valid.

Decomposition:
- No shared package types. Optionally, a shared constant for the maximum WIDTH (64) in the team arithmetic package.
- One sub-module, fa_cell: a purely combinational 1-bit full adder with ports a, b, cin, s, cout. It is instantiated WIDTH times in a generate loop.
- The top-level full_adder_unit holds the carry chain wiring, the output registers and the valid logic.

Test Plan:
- WIDTH=1 exhaustive truth table: all 8 combinations of (a,b,c), each with in_valid=1. Required (a,b,c -> s,cout): 000->0,0; 001->1,0; 010->1,0; 011->0,1; 100->1,0; 101->0,1; 110->0,1; 111->1,1. Each result appears one cycle later with out_valid=1.
- Toggle pattern, WIDTH=1: a toggles every cycle, b and c together toggle every 2 cycles. Required sequence of (s,cout): 000->(0,0), 100->(1,0), 011->(0,1), 111->(1,1), then repeat.
- WIDTH=8 overflow: a=0xFF, b=0x01, c=0 -> s=0x00, cout=1. Then a=0xFF, b=0xFF, c=1 -> s=0xFF, cout=1.
- Hold and valid: after a=5, b=3, c=0 (WIDTH=8), s=0x08. Drive in_valid=0 with a=0x7F for 3 cycles: s stays 0x08, cout stays 0, out_valid=0.
- Asynchronous reset mid-stream: with s=0x08 valid, pulse rst between clock edges. s=0, cout=0 and out_valid=0 immediately, before the next edge. After release, the first valid input gives its correct result one cycle later.
- Randomized WIDTH=16: 1000 random (a,b,c) with in_valid held high. Each cycle, {cout,s} equals the 17-bit a+b+c from the previous cycle.
